// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the single L2 request port among NUM_REQ requesters,
// with one outstanding transaction, response routing and timeout-to-error completion.
module l2_req_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*64-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [NUM_REQ*64-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  output logic [63:0]            resp_rdata_o,
  output logic                   resp_err_o,
  output logic                   l2_req_valid_o,
  output logic [63:0]            l2_req_addr_o,
  output logic                   l2_req_write_o,
  output logic [63:0]            l2_req_wdata_o,
  input  logic                   l2_req_ready_i,
  input  logic                   l2_resp_valid_i,
  input  logic [63:0]            l2_resp_rdata_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IW    = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        rdata_q;
  logic               err_q;

  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [IW-1:0]      idx;
  logic [PTR_W-1:0]   sel;
  logic [63:0]        win_addr, win_wdata;
  logic               win_write;

  // Scan from rr_ptr upward, wrapping, and take the first valid requester.
  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = '0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + IW'(k);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      sel = idx[PTR_W-1:0];
      if (!win_valid && req_valid_i[sel]) begin
        win_valid = 1'b1;
        win_idx   = sel;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr  = req_addr_i[i*64 +: 64];
        win_wdata = req_wdata_i[i*64 +: 64];
        win_write = req_write_i[i];
      end
    end
  end

  // Acceptance is combinational in IDLE; held low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      IDLE:  if (win_valid && !rst) begin
               req_ready_o[win_idx] = 1'b1;
               state_d              = ISSUE;
             end
      ISSUE: if (l2_req_ready_i) state_d = WAIT;
      WAIT:  if (l2_resp_valid_i || cnt_q == CNT_LAST) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the latched request fields are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      cnt_q          <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      l2_req_addr_o  <= '0;
      l2_req_write_o <= 1'b0;
      l2_req_wdata_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (win_valid) begin
          owner_q        <= win_idx;
          rr_ptr_q       <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          l2_req_addr_o  <= win_addr;
          l2_req_write_o <= win_write;
          l2_req_wdata_o <= win_wdata;
        end
        ISSUE: if (l2_req_ready_i) cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (l2_resp_valid_i) begin
            rdata_q <= l2_req_write_o ? 64'd0 : l2_resp_rdata_i;
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign l2_req_valid_o = (state_q == ISSUE);
  assign resp_rdata_o   = (state_q == RESP) ? rdata_q : 64'd0;
  assign resp_err_o     = (state_q == RESP) && err_q;

  always_comb begin
    resp_valid_o = '0;
    if (state_q == RESP) resp_valid_o[owner_q] = 1'b1;
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter: transaction-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then a randomized run.
module tb_l2_req_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_write, req_ready, resp_valid;
  logic [N*64-1:0]   req_addr, req_wdata;
  logic [63:0]       resp_rdata, l2_req_addr, l2_req_wdata, l2_resp_rdata;
  logic              resp_err, l2_req_valid, l2_req_write, l2_req_ready, l2_resp_valid;

  l2_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .l2_req_valid_o(l2_req_valid), .l2_req_addr_o(l2_req_addr),
    .l2_req_write_o(l2_req_write), .l2_req_wdata_o(l2_req_wdata),
    .l2_req_ready_i(l2_req_ready), .l2_resp_valid_i(l2_resp_valid),
    .l2_resp_rdata_i(l2_resp_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester intentions: a pending request stays valid until the model sees it accepted.
  bit          pend[N];
  logic [63:0] r_addr[N], r_wdata[N];
  bit          r_write[N];
  bit          refill;

  // Reference model: one transaction record plus a round-robin pointer.
  bit          m_busy, m_issued, m_cpl, m_write, m_cpl_err;
  int          m_owner, m_rr, m_cpl_owner, m_h_cyc, cyc;
  logic [63:0] m_addr, m_wdata, m_cpl_data;

  // What the DUT was seen doing, for the literal expectations.
  logic [63:0] gr_q[$], ho_cyc[$], ho_addr[$], ho_write[$], ho_wdata[$];
  logic [63:0] cp_valid[$], cp_rdata[$], cp_err[$], cp_cyc[$];
  logic [N-1:0] s_ready, s_rv;
  logic         s_l2v, s_err;
  logic [63:0]  s_addr, s_wdata, s_rdata;

  function automatic logic [63:0] nth(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_issued = 0; m_cpl = 0; m_write = 0; m_cpl_err = 0;
    m_owner = 0; m_rr = 0; m_cpl_owner = 0; m_h_cyc = 0;
    m_addr = '0; m_wdata = '0; m_cpl_data = '0;
  endtask

  task automatic clear_logs();
    gr_q.delete(); ho_cyc.delete(); ho_addr.delete(); ho_write.delete(); ho_wdata.delete();
    cp_valid.delete(); cp_rdata.delete(); cp_err.delete(); cp_cyc.delete();
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend[i];
      req_write[i]           = r_write[i];
      req_addr[i*64 +: 64]   = r_addr[i];
      req_wdata[i*64 +: 64]  = r_wdata[i];
    end
  endtask

  task automatic new_req(input int i, input logic [63:0] a, input bit w, input logic [63:0] d);
    pend[i] = 1; r_addr[i] = a; r_write[i] = w; r_wdata[i] = d;
  endtask

  task automatic compare();
    logic [N-1:0] e_ready, e_rv;
    logic         e_l2v, e_err;
    logic [63:0]  e_rd;
    int           g;
    e_ready = '0; e_rv = '0; e_l2v = 0; e_err = 0; e_rd = '0;
    if (!rst) begin
      if (m_cpl) begin
        e_rv[m_cpl_owner] = 1'b1; e_rd = m_cpl_data; e_err = m_cpl_err;
      end else if (!m_busy) begin
        g = pick(req_valid, m_rr);
        if (g >= 0) e_ready[g] = 1'b1;
      end else if (!m_issued) begin
        e_l2v = 1'b1;
      end
    end
    check("req_ready", req_ready, e_ready);
    check("l2_req_valid", l2_req_valid, e_l2v);
    check("l2_req_addr", l2_req_addr, m_addr);
    check("l2_req_write", l2_req_write, m_write);
    check("l2_req_wdata", l2_req_wdata, m_wdata);
    check("resp_valid", resp_valid, e_rv);
    check("resp_rdata", resp_rdata, e_rd);
    check("resp_err", resp_err, e_err);
    s_ready = req_ready; s_rv = resp_valid; s_l2v = l2_req_valid; s_err = resp_err;
    s_addr = l2_req_addr; s_wdata = l2_req_wdata; s_rdata = resp_rdata;
    if (!rst) begin
      if (req_ready != '0) gr_q.push_back(64'(req_ready));
      if (l2_req_valid && l2_req_ready) begin
        ho_cyc.push_back(64'(cyc)); ho_addr.push_back(l2_req_addr);
        ho_write.push_back(64'(l2_req_write)); ho_wdata.push_back(l2_req_wdata);
      end
      if (resp_valid != '0) begin
        cp_valid.push_back(64'(resp_valid)); cp_rdata.push_back(resp_rdata);
        cp_err.push_back(64'(resp_err)); cp_cyc.push_back(64'(cyc));
      end
    end
  endtask

  task automatic model_update();
    int g;
    if (rst) model_reset();
    else if (m_cpl) begin
      m_cpl = 0; m_busy = 0; m_issued = 0;
    end else if (!m_busy) begin
      g = pick(req_valid, m_rr);
      if (g >= 0) begin
        m_busy = 1; m_issued = 0; m_owner = g; m_rr = (g + 1) % N;
        m_addr = req_addr[g*64 +: 64]; m_wdata = req_wdata[g*64 +: 64]; m_write = req_write[g];
        if (!refill) pend[g] = 0;
      end
    end else if (!m_issued) begin
      if (l2_req_ready) begin m_issued = 1; m_h_cyc = cyc; end
    end else if (l2_resp_valid) begin
      m_cpl = 1; m_cpl_owner = m_owner; m_cpl_err = 0;
      m_cpl_data = m_write ? 64'd0 : l2_resp_rdata;
    end else if (cyc - m_h_cyc == TMO) begin
      m_cpl = 1; m_cpl_owner = m_owner; m_cpl_err = 1; m_cpl_data = '0;
    end
    cyc++;
  endtask

  task automatic step();
    drive_reqs();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic bound_fail(input string name);
    n_vec++; n_mis++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!m_busy && n < 50) begin step(); n++; end
    if (!m_busy) bound_fail(name);
  endtask

  task automatic wait_handoff(input string name);
    int n = 0;
    while (!m_issued && n < 50) begin step(); n++; end
    if (!m_issued) bound_fail(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    l2_req_ready = 1; l2_resp_valid = 1;
    while ((pend[0] || pend[1] || pend[2] || m_busy || m_cpl) && n < 200) begin step(); n++; end
    if (m_busy || m_cpl) bound_fail(name);
    l2_resp_valid = 0;
  endtask

  task automatic reset_pulse();
    rst = 1; model_reset(); step();
    rst = 0; step();
  endtask

  initial begin
    int c0, n;
    rst = 1; refill = 0; cyc = 0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_rdata = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_write[i] = 0; end
    model_reset();
    step(); step();
    check("reset req_ready", s_ready, '0);
    check("reset resp_valid", s_rv, '0);
    rst = 0; step();

    // Single read from requester 1, L2 answers on the third WAIT cycle.
    clear_logs();
    l2_req_ready = 1;
    new_req(1, 64'h1000, 0, 64'h0);
    wait_handoff("t1 handoff");
    step(); step();
    l2_resp_valid = 1; l2_resp_rdata = 64'hDEAD_BEEF; step();
    l2_resp_valid = 0; step(); step();
    check("t1 grant", nth(gr_q, 0), 64'b010);
    check("t1 l2 addr", nth(ho_addr, 0), 64'h1000);
    check("t1 cpl valid", nth(cp_valid, 0), 64'b010);
    check("t1 cpl rdata", nth(cp_rdata, 0), 64'hDEAD_BEEF);
    check("t1 cpl err", nth(cp_err, 0), 64'd0);
    check("t1 latency", nth(cp_cyc, 0) - nth(ho_cyc, 0), 64'd4);

    // Round-robin with all three requesters held valid.
    reset_pulse(); clear_logs();
    refill = 1;
    for (int i = 0; i < N; i++) new_req(i, {$urandom, $urandom}, 0, 64'h0);
    l2_req_ready = 1; l2_resp_valid = 1; l2_resp_rdata = 64'h77;
    n = 0;
    while (gr_q.size() < 6 && n < 200) begin step(); n++; end
    refill = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    drain("t2 drain");
    for (int i = 0; i < 6; i++) check($sformatf("t2 grant %0d", i), nth(gr_q, i), 64'(1 << (i % 3)));

    // Backpressure: ready low for five ISSUE cycles, handoff on the sixth.
    clear_logs();
    l2_req_ready = 0;
    new_req(0, 64'hABC0, 1, 64'h1234);
    wait_busy("t3 grant");
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3 held valid", s_l2v, 1'b1);
      check("t3 held addr", s_addr, 64'hABC0);
      check("t3 held wdata", s_wdata, 64'h1234);
    end
    l2_req_ready = 1; step();
    check("t3 handoff cycle", nth(ho_cyc, 0), 64'(c0 + 5));
    l2_resp_valid = 1; l2_resp_rdata = 64'h9999; step();
    l2_resp_valid = 0; step(); step();
    check("t3 write cpl rdata", nth(cp_rdata, 0), 64'd0);

    // Timeout: no L2 response at all, then a late stray one.
    clear_logs();
    new_req(2, 64'h2000, 0, 64'h0);
    wait_handoff("t4 handoff");
    n = 0;
    while (cp_valid.size() == 0 && n < 30) begin step(); n++; end
    check("t4 cpl valid", nth(cp_valid, 0), 64'b100);
    check("t4 cpl err", nth(cp_err, 0), 64'd1);
    check("t4 cpl rdata", nth(cp_rdata, 0), 64'd0);
    check("t4 timeout latency", nth(cp_cyc, 0) - nth(ho_cyc, 0), 64'd9);
    l2_resp_valid = 1; l2_resp_rdata = 64'h1111; step();
    l2_resp_valid = 0; step(); step();
    check("t4 late resp ignored", 64'(cp_valid.size()), 64'd1);

    // Write from requester 2.
    clear_logs();
    new_req(2, 64'h40, 1, 64'h55);
    wait_handoff("t5 handoff");
    l2_resp_valid = 1; l2_resp_rdata = 64'hFFFF_FFFF; step();
    l2_resp_valid = 0; step(); step();
    check("t5 l2 write", nth(ho_write, 0), 64'd1);
    check("t5 l2 addr", nth(ho_addr, 0), 64'h40);
    check("t5 l2 wdata", nth(ho_wdata, 0), 64'h55);
    check("t5 cpl valid", nth(cp_valid, 0), 64'b100);
    check("t5 cpl rdata", nth(cp_rdata, 0), 64'd0);
    check("t5 cpl err", nth(cp_err, 0), 64'd0);

    // Reset while in WAIT: everything drops, the owner never completes, rr_ptr returns to 0.
    clear_logs();
    new_req(1, 64'h3000, 0, 64'h0);
    wait_handoff("t6 handoff");
    step();
    rst = 1; model_reset(); step();
    check("t6 rst resp_valid", s_rv, '0);
    check("t6 rst l2 valid", s_l2v, 1'b0);
    check("t6 rst l2 addr", s_addr, 64'd0);
    check("t6 rst rdata", s_rdata, 64'd0);
    rst = 0; l2_resp_valid = 1; l2_resp_rdata = 64'h4444; step();
    l2_resp_valid = 0; step(); step();
    check("t6 no completion", 64'(cp_valid.size()), 64'd0);
    new_req(0, 64'h5000, 0, 64'h0);
    new_req(2, 64'h6000, 0, 64'h0);
    step();
    check("t6 grant after reset", nth(gr_q, 1), 64'b001);
    drain("t6 drain");

    // Randomized traffic with occasional stray responses, stalls, timeouts and resets.
    reset_pulse();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 9) < 3)
          new_req(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      l2_req_ready  = ($urandom_range(0, 9) < 7);
      l2_resp_valid = ($urandom_range(0, 9) < 2);
      l2_resp_rdata = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin rst = 1; model_reset(); end
      else rst = 0;
      step();
    end
    rst = 0;
    drain("random drain");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
